// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential binary-to-BCD converter (double dabble, one bit
//               per clock). Produces a 4-digit packed BCD word, thousands
//               digit in [15:12], with a start/busy/valid handshake.
//               Inputs above 9999 saturate the result to 16'h9999 and raise
//               overflow.
//               Optional macro BCD_DIV3_FLAG_EN adds a div3 output that flags
//               whether the original binary operand is divisible by three.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             valid,
    output logic [15:0]      bcd,
    output logic             overflow
`ifdef BCD_DIV3_FLAG_EN
    ,
    output logic             div3
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_shift = 2'd1;
    localparam logic [1:0]  c_st_done  = 2'd2;

    // Count value seen during the final shift cycle.
    localparam logic [3:0]  c_last     = 4'(BIN_W - 1);
    localparam logic [13:0] c_max_bcd  = 14'd9999;
    localparam logic [15:0] c_sat_bcd  = 16'h9999;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [BIN_W-1:0] r_shift;
    logic [15:0]      r_scratch;
    logic [3:0]       r_count;
    logic             r_ovf_pending;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [15:0]      w_adj;
    logic [15:0]      w_next_scratch;
    logic [BIN_W-1:0] w_next_shift;
    logic             w_out_bit;
    logic             w_last;
    logic             w_accept;
    logic [13:0]      w_bin_ext;
    logic             w_bin_ovf;

    // Zero-extend the operand to 14 bits so the saturation compare has a
    // single fixed width regardless of BIN_W.
    generate
        if (BIN_W == 14) begin : g_ext_full
            assign w_bin_ext = bin;
        end else begin : g_ext_pad
            assign w_bin_ext = {{(14 - BIN_W){1'b0}}, bin};
        end
    endgenerate

    assign w_bin_ovf = (w_bin_ext > c_max_bcd);

    // A new conversion may be accepted in IDLE and also in the DONE cycle,
    // which gives back-to-back throughput of one result per BIN_W+1 cycles.
    assign w_accept  = start && ((r_state == c_st_idle) || (r_state == c_st_done));

    assign w_last    = (r_count == c_last);
    assign w_out_bit = r_shift[BIN_W-1];

    // Add-3 correction: every digit >= 5 is bumped by 3 before the shift so
    // that the doubled value carries correctly into the next digit.
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < 4; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // The MSB of the binary operand moves into the bottom of the digits.
    assign w_next_scratch = {w_adj[14:0], w_out_bit};
    assign w_next_shift   = r_shift << 1;

`ifdef BCD_DIV3_FLAG_EN
    // ------------------------------------------------------------------------
    // Divisibility-by-3 residue: tracks (binary prefix mod 3) as bits leave
    // the shift register, MSB first, so it reflects the original operand even
    // when the BCD result saturates.
    // ------------------------------------------------------------------------
    logic [1:0] r_res;
    logic [1:0] w_res_next;

    // Residue step: (2*r + bit) mod 3.
    always_comb begin
        w_res_next = 2'd0;
        case ({r_res, w_out_bit})
            3'b00_0: w_res_next = 2'd0;
            3'b00_1: w_res_next = 2'd1;
            3'b01_0: w_res_next = 2'd2;
            3'b01_1: w_res_next = 2'd0;
            3'b10_0: w_res_next = 2'd1;
            3'b10_1: w_res_next = 2'd2;
            default: w_res_next = 2'd0;
        endcase
    end

    // Residue register and div3 flag, updated alongside overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= 2'd0;
            div3  <= 1'b0;
        end else if (w_accept) begin
            r_res <= 2'd0;
        end else if (r_state == c_st_shift) begin
            r_res <= w_res_next;
            if (w_last) begin
                div3 <= (w_res_next == 2'd0);
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Control FSM and datapath with registered outputs
    // ------------------------------------------------------------------------
    // Single sequential block: FSM, shift datapath and all result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_shift       <= '0;
            r_scratch     <= 16'h0000;
            r_count       <= 4'd0;
            r_ovf_pending <= 1'b0;
            busy          <= 1'b0;
            valid         <= 1'b0;
            bcd           <= 16'h0000;
            overflow      <= 1'b0;
        end else begin
            // valid is a single-cycle pulse; it is only raised on the last
            // shift below.
            valid <= 1'b0;

            case (r_state)
                c_st_idle,
                c_st_done: begin
                    if (w_accept) begin
                        r_shift       <= bin;
                        r_scratch     <= 16'h0000;
                        r_count       <= 4'd0;
                        r_ovf_pending <= w_bin_ovf;
                        busy          <= 1'b1;
                        r_state       <= c_st_shift;
                    end else begin
                        r_state       <= c_st_idle;
                    end
                end

                c_st_shift: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= w_next_shift;
                    r_count   <= r_count + 4'd1;
                    if (w_last) begin
                        // Publish the result so it is visible during DONE.
                        busy     <= 1'b0;
                        valid    <= 1'b1;
                        bcd      <= r_ovf_pending ? c_sat_bcd : w_next_scratch;
                        overflow <= r_ovf_pending;
                        r_state  <= c_st_done;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
